pcie_rx_block_align_130b: RTL and testbench

Receive-side 128b/130b block aligner and sync-header decoder for the Gen3 PHY. It takes the raw, unaligned 128-bit deserialized word stream and hunts for 130-bit block boundaries using the 2-bit sync headers. Once locked, it strips the headers and emits 128-bit payloads with a control/data flag. Its outputs feed pcie_descrambler_128b directly: out_data maps to in_data, out_valid to in_valid, and out_is_ctl to in_is_ctl.

---
 rtl/pcie_phy_pkg.sv | 18 +
 rtl/pcie_rx_gearbox_130b.sv | 61 ++++++
 rtl/pcie_rx_block_align_130b.sv | 136 +++++++++++++
 tb/tb_pcie_rx_block_align_130b.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/pcie_phy_pkg.sv
// rtl/pcie_phy_pkg.sv - shared 128b/130b sync-header constants, types and helpers
package pcie_phy_pkg;

  localparam logic [1:0] SYNC_DATA = 2'b10;
  localparam logic [1:0] SYNC_OS   = 2'b01;
  localparam int         BLK_W     = 130;

  typedef enum logic {
    HUNT   = 1'b0,
    LOCKED = 1'b1
  } align_state_t;

  // Only the two mixed patterns are legal sync headers.
  function automatic logic is_valid_hdr(input logic [1:0] hdr);
    return (hdr == SYNC_DATA) || (hdr == SYNC_OS);
  endfunction

endpackage

// File: rtl/pcie_rx_gearbox_130b.sv
// rtl/pcie_rx_gearbox_130b.sv - 128-bit word to 130-bit block gearbox with one-bit slip
module pcie_rx_gearbox_130b
  import pcie_phy_pkg::*;
#(
  parameter int DW = 128
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [DW-1:0] in_data,
  input  logic          in_valid,
  input  logic          slip,
  output logic          blk_valid,
  output logic [1:0]    blk_hdr,
  output logic [DW-1:0] blk_payload
);

  // Worst case held bits: 130 (slip pending, no extract) plus one new word.
  localparam int BUF_W = 2 * BLK_W - 2;
  localparam int CNT_W = 9;

  logic [BUF_W-1:0] bit_buf_q;
  logic [BUF_W-1:0] merged;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] avail;
  logic [CNT_W-1:0] need;
  logic             slip_pend_q;

  // Append the new word above the held bits and present the oldest block.
  always_comb begin
    merged = bit_buf_q;
    avail  = cnt_q;
    if (in_valid) begin
      merged = bit_buf_q | (BUF_W'(in_data) << cnt_q);
      avail  = cnt_q + CNT_W'(DW);
    end
    need        = slip_pend_q ? CNT_W'(BLK_W + 1) : CNT_W'(BLK_W);
    blk_valid   = (avail >= need);
    blk_hdr     = slip_pend_q ? merged[2:1] : merged[1:0];
    blk_payload = slip_pend_q ? merged[DW+2:3] : merged[DW+1:2];
  end

  // Consume one block (plus the slipped bit) when enough bits are held.
  always_ff @(posedge clk) begin
    if (rst) begin
      bit_buf_q   <= '0;
      cnt_q       <= '0;
      slip_pend_q <= 1'b0;
    end else begin
      if (blk_valid) begin
        bit_buf_q   <= merged >> need;
        cnt_q       <= avail - need;
        slip_pend_q <= slip;
      end else begin
        bit_buf_q   <= merged;
        cnt_q       <= avail;
        slip_pend_q <= slip_pend_q | slip;
      end
    end
  end

endmodule

// File: rtl/pcie_rx_block_align_130b.sv
// rtl/pcie_rx_block_align_130b.sv - 128b/130b block aligner with lock FSM and header decode
module pcie_rx_block_align_130b
  import pcie_phy_pkg::*;
#(
  parameter int DW         = 128,
  parameter int LOCK_CNT   = 8,
  parameter int UNLOCK_CNT = 4,
  parameter int WIN_LEN    = 64
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [DW-1:0] in_data,
  input  logic          in_valid,
  output logic [DW-1:0] out_data,
  output logic          out_valid,
  output logic          out_is_ctl,
  output logic          out_hdr_err,
  output logic          block_lock
);

  localparam int GW = $clog2(LOCK_CNT + 1);
  localparam int BW = $clog2(UNLOCK_CNT + 1);
  localparam int WW = $clog2(WIN_LEN + 1);

  if (DW != 128) begin : g_dw_check
    $error("pcie_rx_block_align_130b: DW must be 128");
  end

  align_state_t   state_q, state_d;
  logic [GW-1:0]  good_q, good_d;
  logic [BW-1:0]  bad_q, bad_d;
  logic [WW-1:0]  win_q, win_d;
  logic           blk_valid;
  logic [1:0]     blk_hdr;
  logic [DW-1:0]  blk_payload;
  logic           slip;
  logic           hdr_ok;
  logic           emit;

  pcie_rx_gearbox_130b #(.DW(DW)) u_gearbox (
    .clk         (clk),
    .rst         (rst),
    .in_data     (in_data),
    .in_valid    (in_valid),
    .slip        (slip),
    .blk_valid   (blk_valid),
    .blk_hdr     (blk_hdr),
    .blk_payload (blk_payload)
  );

  // Lock hunting, error-window tracking and slip requests, one block at a time.
  always_comb begin
    state_d = state_q;
    good_d  = good_q;
    bad_d   = bad_q;
    win_d   = win_q;
    slip    = 1'b0;
    hdr_ok  = is_valid_hdr(blk_hdr);
    if (blk_valid) begin
      case (state_q)
        HUNT: begin
          if (!hdr_ok) begin
            good_d = '0;
            slip   = 1'b1;
          end else if (good_q == GW'(LOCK_CNT - 1)) begin
            state_d = LOCKED;
            good_d  = '0;
            bad_d   = '0;
            win_d   = '0;
          end else begin
            good_d = good_q + 1'b1;
          end
        end
        LOCKED: begin
          // Unlock takes priority over the window rollover on the same block.
          if (!hdr_ok && (bad_q == BW'(UNLOCK_CNT - 1))) begin
            state_d = HUNT;
            good_d  = '0;
            bad_d   = '0;
            win_d   = '0;
            slip    = 1'b1;
          end else if (win_q == WW'(WIN_LEN - 1)) begin
            win_d = '0;
            bad_d = '0;
          end else begin
            win_d = win_q + 1'b1;
            if (!hdr_ok) begin
              bad_d = bad_q + 1'b1;
            end
          end
        end
        default: state_d = HUNT;
      endcase
    end
    // The locking block and the unlocking block are both presented.
    emit = blk_valid && ((state_q == LOCKED) || (state_d == LOCKED));
  end

  // FSM state and counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= HUNT;
      good_q  <= '0;
      bad_q   <= '0;
      win_q   <= '0;
    end else begin
      state_q <= state_d;
      good_q  <= good_d;
      bad_q   <= bad_d;
      win_q   <= win_d;
    end
  end

  // Registered payload and flags, one cycle after the block completes.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_data    <= '0;
      out_valid   <= 1'b0;
      out_is_ctl  <= 1'b0;
      out_hdr_err <= 1'b0;
    end else begin
      out_valid <= emit;
      if (emit) begin
        out_data    <= blk_payload;
        out_is_ctl  <= hdr_ok && (blk_hdr == SYNC_OS);
        out_hdr_err <= !hdr_ok;
      end else begin
        out_is_ctl  <= 1'b0;
        out_hdr_err <= 1'b0;
      end
    end
  end

  assign block_lock = (state_q == LOCKED);

endmodule

// File: tb/tb_pcie_rx_block_align_130b.sv
// tb/tb_pcie_rx_block_align_130b.sv - table-driven bench for the 128b/130b block aligner
module tb_pcie_rx_block_align_130b;

  localparam int DW = 128;

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] in_data;
  logic          in_valid;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          out_is_ctl;
  logic          out_hdr_err;
  logic          block_lock;

  pcie_rx_block_align_130b dut (
    .clk         (clk),
    .rst         (rst),
    .in_data     (in_data),
    .in_valid    (in_valid),
    .out_data    (out_data),
    .out_valid   (out_valid),
    .out_is_ctl  (out_is_ctl),
    .out_hdr_err (out_hdr_err),
    .block_lock  (block_lock)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]   hdr;
    logic [127:0] payload;
    bit           emit;
    logic         is_ctl;
    logic         hdr_err;
    logic         lock;
  } blk_vec_t;

  typedef struct {
    logic [127:0] data;
    logic         is_ctl;
    logic         hdr_err;
    logic         lock;
  } exp_t;

  blk_vec_t vec_a[96];
  blk_vec_t vec_b[15];
  int       bad_idx[7] = '{20, 30, 40, 75, 80, 85, 90};
  bit       wire_q[$];
  exp_t     exp_q[$];
  exp_t     mon_e;
  int       n_checks = 0;
  int       n_fail   = 0;
  int       n_pulses = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  task automatic push_zero_bits(input int n);
    for (int i = 0; i < n; i++) wire_q.push_back(1'b0);
  endtask

  task automatic push_vec(input blk_vec_t v);
    exp_t e;
    wire_q.push_back(v.hdr[0]);
    wire_q.push_back(v.hdr[1]);
    for (int i = 0; i < 128; i++) wire_q.push_back(v.payload[i]);
    if (v.emit) begin
      e.data    = v.payload;
      e.is_ctl  = v.is_ctl;
      e.hdr_err = v.hdr_err;
      e.lock    = v.lock;
      exp_q.push_back(e);
    end
  endtask

  // Present n words from the wire queue; optionally an idle cycle after each.
  task automatic feed_words(input int n, input bit idle_after);
    logic [DW-1:0] w;
    for (int k = 0; k < n; k++) begin
      for (int b = 0; b < DW; b++) w[b] = (wire_q.size() > 0) ? wire_q.pop_front() : 1'b0;
      in_data  = w;
      in_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      #1;
      if (idle_after) begin
        in_valid = 1'b0;
        in_data  = {4{$urandom()}};
        @(posedge clk);
        @(negedge clk);
        #1;
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic apply_reset(input int cycles, input string tag);
    rst      = 1'b1;
    in_valid = 1'b1;
    in_data  = {4{$urandom()}};
    repeat (cycles) @(posedge clk);
    @(negedge clk);
    #1;
    check({tag, "_out_data"}, out_data, '0);
    check({tag, "_out_valid"}, 128'(out_valid), 128'(0));
    check({tag, "_out_is_ctl"}, 128'(out_is_ctl), 128'(0));
    check({tag, "_out_hdr_err"}, 128'(out_hdr_err), 128'(0));
    check({tag, "_block_lock"}, 128'(block_lock), 128'(0));
    rst      = 1'b0;
    in_valid = 1'b0;
    wire_q.delete();
    exp_q.delete();
    n_pulses = 0;
  endtask

  // Scoreboard: every out_valid must match the next expected block.
  always @(negedge clk) begin
    if (out_valid) begin
      n_pulses++;
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_out_valid: got out_valid=1 expected 0 (data %h)", out_data);
      end else begin
        mon_e = exp_q.pop_front();
        check("blk_data", out_data, mon_e.data);
        check("blk_ctl_err_lock", 128'({out_is_ctl, out_hdr_err, block_lock}),
              128'({mon_e.is_ctl, mon_e.hdr_err, mon_e.lock}));
      end
    end
  end

  initial begin
    // Phase A table: aligned data blocks, one OS block, scattered bad headers.
    for (int i = 0; i < 96; i++) begin
      vec_a[i] = '{hdr: 2'b10, payload: '0, emit: (i >= 7 && i <= 90),
                   is_ctl: 1'b0, hdr_err: 1'b0, lock: 1'b1};
    end
    vec_a[9].hdr     = 2'b01;
    vec_a[9].payload = 128'hDEADBEEF_CAFEBABE_12345678_9ABCDEF0;
    vec_a[9].is_ctl  = 1'b1;
    foreach (bad_idx[j]) begin
      vec_a[bad_idx[j]].hdr     = 2'b11;
      vec_a[bad_idx[j]].hdr_err = 1'b1;
    end
    vec_a[90].lock = 1'b0;

    // Phase B table: stream behind a 3-bit prefix, lock on block index 10.
    for (int i = 0; i < 15; i++) begin
      vec_b[i] = '{hdr: 2'b10, payload: '0, emit: (i >= 10),
                   is_ctl: 1'b0, hdr_err: 1'b0, lock: 1'b1};
    end
    for (int i = 11; i < 15; i++) vec_b[i].payload = {4{32'hA5A5_0000 + 32'(i)}};

    in_data  = '0;
    in_valid = 1'b0;
    apply_reset(3, "reset");

    // Phase A: lock at word 9, 64 blocks per 65 words, window and unlock rules.
    for (int i = 0; i < 96; i++) push_vec(vec_a[i]);
    feed_words(8, 1'b0);
    check("a_lock_before_8", 128'(block_lock), 128'(0));
    check("a_pulses_before_8", 128'(n_pulses), 128'(0));
    feed_words(1, 1'b0);
    check("a_lock_at_8", 128'(block_lock), 128'(1));
    check("a_pulses_at_8", 128'(n_pulses), 128'(1));
    feed_words(65, 1'b0);
    check("a_pulses_65_words", 128'(n_pulses - 1), 128'(64));
    feed_words(23, 1'b0);
    check("a_lock_after_unlock", 128'(block_lock), 128'(0));
    check("a_pulses_total", 128'(n_pulses), 128'(84));
    check("a_exp_drained", 128'(exp_q.size()), 128'(0));

    // Phase B: three slips hunt out the 3-bit prefix.
    apply_reset(1, "reset_b");
    push_zero_bits(3);
    for (int i = 0; i < 15; i++) push_vec(vec_b[i]);
    feed_words(11, 1'b0);
    check("b_lock_before_11", 128'(block_lock), 128'(0));
    check("b_pulses_before_11", 128'(n_pulses), 128'(0));
    feed_words(1, 1'b0);
    check("b_lock_at_11", 128'(block_lock), 128'(1));
    feed_words(4, 1'b0);
    check("b_pulses_total", 128'(n_pulses), 128'(5));
    check("b_exp_drained", 128'(exp_q.size()), 128'(0));
    check("b_data_before_reset", out_data, vec_b[14].payload);

    // Mid-stream reset while locked, then relock with idle gaps between words.
    apply_reset(1, "midreset");
    for (int i = 0; i < 9; i++) push_vec(vec_a[i]);
    feed_words(8, 1'b1);
    check("c_lock_before_8", 128'(block_lock), 128'(0));
    feed_words(1, 1'b1);
    check("c_lock_at_8", 128'(block_lock), 128'(1));
    check("c_pulses_at_8", 128'(n_pulses), 128'(1));
    feed_words(1, 1'b1);
    check("c_pulses_total", 128'(n_pulses), 128'(2));
    check("c_exp_drained", 128'(exp_q.size()), 128'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
